// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

  // Default number of index bits; the cache holds 2**IDX_W one-word lines.
  localparam int IDX_W_DEF = 6;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2
  } state_t;

endpackage

// File: rtl/icache_mem.sv
// Line storage for the instruction cache: valid flags, tags and data words.
// One combinational read port, one synchronous write port, synchronous clear-all.
module icache_mem
  import icache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             clr
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Valid flags: clear-all beats a fill in the same cycle so a flushed fill stays invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents need no reset; they are meaningless until the valid flag is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetch stage and the memory controller.
// Hits answer one cycle after the request; misses fetch one word from mct and fill the line.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_e,
  input  logic [31:0] if_a,
  output logic        if_ok,
  output logic [31:0] if_n,
  input  logic        inv,
  input  logic        flush,
  output logic        mct_e,
  output logic [31:0] mct_a,
  input  logic        mct_ok,
  input  logic [31:0] mct_n
);

  localparam int TAG_W = 30 - IDX_W;

  state_t             state_q, state_d;
  logic [31:0]        req_a_q;
  logic               aborted_q;
  logic               mct_e_q;
  logic [31:0]        mct_a_q;
  logic [31:0]        if_n_q;

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               hit;
  logic               start_miss;
  logic               fill;
  logic               accept;

  assign req_idx = req_a_q[IDX_W+1:2];
  assign req_tag = req_a_q[31:IDX_W+2];
  assign hit     = rd_valid && (rd_tag == req_tag);
  assign accept  = (state_q == IDLE) && if_e && !inv;

  icache_mem #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill),
    .wr_idx   (req_idx),
    .wr_tag   (req_tag),
    .wr_data  (mct_n),
    .clr      (flush)
  );

  // Next-state and response logic; a lookup reads the array before any same-cycle flush lands.
  always_comb begin
    state_d    = state_q;
    if_ok      = 1'b0;
    start_miss = 1'b0;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (inv) begin
          state_d = IDLE;
        end else if (hit) begin
          if_ok   = 1'b1;
          state_d = IDLE;
        end else begin
          start_miss = 1'b1;
          state_d    = MISS;
        end
      end
      MISS: begin
        if (mct_ok) begin
          fill    = 1'b1;
          if_ok   = !aborted_q && !inv;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_n  = if_ok ? ((state_q == LOOKUP) ? rd_data : mct_n) : if_n_q;
  assign mct_e = mct_e_q;
  assign mct_a = mct_a_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Capture the accepted fetch address for the whole lookup/miss sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        req_a_q <= '0;
    else if (accept) req_a_q <= if_a;
  end

  // A redirect during a miss only suppresses the eventual response; the mct fetch still completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aborted_q <= 1'b0;
    else      aborted_q <= (state_q == MISS) && !mct_ok && (aborted_q || inv);
  end

  // Miss request to mct, held stable until the controller answers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mct_e_q <= 1'b0;
      mct_a_q <= '0;
    end else if (start_miss) begin
      mct_e_q <= 1'b1;
      mct_a_q <= req_a_q & ~32'h3;
    end else if (fill) begin
      mct_e_q <= 1'b0;
    end
  end

  // Remember the last delivered word so if_n holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       if_n_q <= '0;
    else if (if_ok) if_n_q <= if_n;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the fetch stage (inf) and the memory controller (mct).
- Hits return an instruction word one cycle after the request.
- Misses issue a single-word fetch to mct. mct fetches byte-serially over the RAM bus, so this access costs several cycles.
- The block removes repeated byte-serial fetches of loop bodies.
- It supports a branch-redirect abort and a full flush.

Parameters:
- IDX_W, 6, index width; the cache holds 2^IDX_W one-word lines.
- TAG_W, 30-IDX_W, tag width, derived; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- if_e  in  1  fetch request valid
- if_a  in  32  fetch address; bits [1:0] ignored
- if_ok  out  1  one-cycle pulse: if_n is valid for the accepted request
- if_n  out  32  instruction word
- inv  in  1  redirect: abort the current request, suppress its if_ok
- flush  in  1  invalidate all lines
- mct_e  out  1  miss fetch request, held until mct_ok
- mct_a  out  32  miss address, word aligned ({tag,idx,2'b00})
- mct_ok  in  1  one-cycle pulse: mct_n valid
- mct_n  in  32  fetched word

Behaviour:
- Address split: idx = a[IDX_W+1:2]; tag = a[31:IDX_W+2].
- Storage:
  - Per line: valid bit, tag, 32-bit data.
  - Valid bits are flops. Tag and data may be flop or RAM arrays with synchronous write.
- Reset (rst=0, asynchronous): all valid bits 0; state IDLE; if_ok=0; if_n=0; mct_e=0; mct_a=0.
- State IDLE:
  - if_e=1 and inv=0 → latch if_a into req_a. Look up. Next state LOOKUP.
  - Otherwise stay in IDLE.
- State LOOKUP:
  - Hit (valid[idx] and tag match): drive if_ok=1 and if_n=data for exactly one cycle. Return to IDLE.
  - Miss: next cycle assert mct_e=1 and mct_a=req_a&~3. Go to MISS.
- Hit latency: if_ok is asserted in the cycle after if_e is sampled.
- Back-to-back requests: a new if_e is not accepted until the state returns to IDLE. One request is in flight at a time.
- State MISS:
  - mct_e and mct_a are held stable until mct_ok.
  - On mct_ok: write line[idx] (valid=1, tag, data=mct_n). In the same cycle drive if_ok=1 and if_n=mct_n. Drop mct_e. Go to IDLE.
- inv during LOOKUP: no if_ok. Go to IDLE.
- inv during MISS:
  - Set the aborted flag. The mct transaction is never cancelled (mct has no abort), so mct_e stays high until mct_ok.
  - On mct_ok the line is still filled, but if_ok stays 0.
  - The next request is accepted only once back in IDLE.
- inv and if_e in the same cycle in IDLE: inv wins; the request is ignored. Fetch re-presents the request next cycle.
- Flush:
  - Clears all valid bits at the clock edge.
  - If a MISS fill completes in the same cycle as flush, the fill is discarded: the line stays invalid. if_ok still fires unless aborted.
  - A LOOKUP coinciding with flush is evaluated against the pre-flush state.
- Hold: if_n holds its last value when if_ok=0. Consumers qualify it with if_ok.
- Width rules:
  - No arithmetic. Tag comparison is exact over TAG_W bits.
  - Addresses wrap naturally: 0xFFFFFFFC maps to idx all-ones.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, LOOKUP=2'd1, MISS=2'd2) and the default IDX_W constant.
- Sub-module icache_mem: valid/tag/data array.
  - One read port, combinational, indexed by idx.
  - One write port, synchronous.
  - Synchronous clear-all for flush.
  - Asynchronous reset of the valid bits.
- The FSM stays in icache.

Test Plan:
- Cold miss:
  - Stimulus: after reset, if_e=1, if_a=0x00000104.
  - Required: after LOOKUP, mct_e=1 with mct_a=0x00000104, held. The bench returns mct_ok with mct_n=0x00A00093 after 8 cycles. if_ok=1 and if_n=0x00A00093 in the same cycle. mct_e=0 the next cycle.
- Warm hit: re-request 0x00000104 → if_ok one cycle later with if_n=0x00A00093; mct_e never asserted.
- Conflict eviction (IDX_W=6):
  - Stimulus: fill 0x00000104, then request 0x00000204 (same idx 1, different tag).
  - Required: miss, with mct_a=0x00000204. A later request to 0x00000104 misses again.
- Redirect mid-miss:
  - Stimulus: miss on 0x00000010; pulse inv two cycles into MISS.
  - Required: mct_e held until mct_ok; no if_ok; a re-request of 0x00000010 then hits.
- Flush: fill 0x00000000, pulse flush, request 0x00000000 → miss (mct_e=1).
- Reset mid-miss:
  - Stimulus: drop rst during MISS.
  - Required: mct_e=0, if_ok=0 immediately (asynchronous). After release, all previous lines miss.
